xmit_frame_scheduler: RTL and testbench
=======================================

Name: xmit_frame_scheduler

Overview:
- Sits between the high-priority and low-priority receive-side frame buffers and the transmit engine in xmitTop, all in the clk_sys domain.
- Arbitrates between the two queues by control block: strict priority with a starvation guard for the low queue.
- Sequences the byte reads out of the selected buffer and starts the transmit engine.
- Drains and discards frames whose length is out of range.

Parameters:
- MIN_LEN, 64: smallest legal frame length in bytes.
- MAX_LEN, 1518: largest legal frame length in bytes.
- IFG_CYCLES, 12: idle clk_sys cycles inserted after every frame (sent or discarded).
- HI_BURST_MAX, 4: consecutive high grants allowed while low is waiting. 0 means pure strict priority.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- hi_frame_valid  in  1  high queue holds a complete frame; hi_ctrl is valid.
- hi_ctrl  in  24  high-queue control block: [23:12] length in bytes, [11:0] frame tag.
- lo_frame_valid  in  1  same as hi_frame_valid, for the low queue.
- lo_ctrl  in  24  same as hi_ctrl, for the low queue.
- tx_ready  in  1  transmit engine can accept a new frame.
- hi_ctrl_pop  out  1  one-cycle pulse that consumes the head high control block.
- lo_ctrl_pop  out  1  one-cycle pulse that consumes the head low control block.
- hi_data_rd  out  1  byte read strobe to the high data buffer.
- lo_data_rd  out  1  byte read strobe to the low data buffer.
- data_sel  out  1  1 = high buffer drives the transmit byte bus.
- tx_start  out  1  one-cycle pulse: a frame begins.
- tx_len  out  12  length of the current frame; held until the next grant.
- tx_tag  out  12  tag of the current frame; held until the next grant.
- discard_en  out  1  high while a bad frame is being drained.
- busy  out  1  high in any state other than IDLE.
- hi_sent_cnt  out  16  count of high frames sent; wraps.
- lo_sent_cnt  out  16  count of low frames sent; wraps.
- drop_cnt  out  16  count of frames discarded; wraps.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - All strobes and pulses are 0; data_sel=0; tx_len=0; tx_tag=0.
  - All counters are 0; the high-streak counter is 0.
  - Reset mid-frame aborts immediately; no pop or drain is completed.
- States: IDLE, XFER, DRAIN, GAP.
- Arbitration (evaluated in IDLE only):
  - Pick low if lo_frame_valid and (!hi_frame_valid, or (HI_BURST_MAX!=0 and streak==HI_BURST_MAX)).
  - Otherwise pick high if hi_frame_valid.
  - Otherwise stay in IDLE.
- Candidate length L=ctrl[23:12]. The frame is good if MIN_LEN<=L<=MAX_LEN.
- Good candidate:
  - Granted only when tx_ready=1; else remain in IDLE and re-arbitrate every cycle.
  - Next cycle: state=XFER; pulse pop and tx_start; latch tx_len/tx_tag; set data_sel.
  - The rd strobe is high for exactly L consecutive cycles, starting with the pop cycle.
- Bad candidate:
  - Granted regardless of tx_ready. Next cycle: state=DRAIN; pulse pop; no tx_start.
  - discard_en and the rd strobe are high for L cycles.
  - If L=0: discard_en is high for 1 cycle with no rd strobe.
- Byte counter: 12-bit, loaded with L, decremented per rd. Leave XFER/DRAIN on the cycle after the last rd; enter GAP.
- GAP:
  - Lasts IFG_CYCLES cycles; if 0, go straight to IDLE.
  - Valid inputs are ignored in every state except IDLE.
- Counters:
  - On a good grant: the matching sent counter +1.
  - On a bad grant: drop_cnt +1.
  - All counters wrap at 16 bits.
- Streak:
  - A high grant (good or bad) increments it, saturating at HI_BURST_MAX.
  - A low grant clears it.
  - Arbitration with high not valid clears it.
- All outputs are registered. Latency: valid+ready in IDLE → pop, tx_start and first rd one cycle later.
- Upstream must present the next control block on the cycle after a pop.

Decomposition:
- Package xmit_pkg holds:
  - the state enum;
  - control-block field positions (LEN_MSB=23, LEN_LSB=12, TAG_MSB=11);
  - default MIN_LEN/MAX_LEN.
- One sub-module, xmit_prio_arbiter: combinational pick plus the streak register. Outputs grant_hi, grant_lo, candidate ctrl.
- The FSM and counters stay in the top module.

Test Plan:
- Single high frame, hi_ctrl=24'h040040, tx_ready=1:
  - one hi_ctrl_pop and one tx_start, tx_len=64, tx_tag=12'h040;
  - hi_data_rd high for 64 cycles, then 12 GAP cycles;
  - hi_sent_cnt=1.
- Both queues continuously valid, length 64, HI_BURST_MAX=4 → grant order H,H,H,H,L,H,H,H,H,L; lo_sent_cnt=2 after 10 frames.
- Runt hi_ctrl=24'h020001 (length 32) → DRAIN:
  - discard_en and hi_data_rd high for 32 cycles;
  - no tx_start; drop_cnt=1.
- L=0 and L=1519 → each discarded; drop_cnt=2; zero-length case shows one discard_en cycle and no rd.
- Good frame with tx_ready=0 for 10 cycles → no pop until tx_ready rises; pop and tx_start one cycle after the rise.
- Reset asserted at byte 30 of an XFER → all outputs 0 asynchronously; after release, IDLE and counters 0.

Source files
------------

// File: rtl/xmit_pkg.sv
// Shared types and constants for the transmit frame scheduler: FSM states,
// control-block field layout and default legal frame-length bounds.
package xmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_GAP
  } state_e;

  localparam int LEN_MSB = 23;
  localparam int LEN_LSB = 12;
  localparam int TAG_MSB = 11;

  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;

  function automatic logic [11:0] ctrl_len(input logic [23:0] ctrl);
    return ctrl[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [11:0] ctrl_tag(input logic [23:0] ctrl);
    return ctrl[TAG_MSB:0];
  endfunction

endpackage

// File: rtl/xmit_prio_arbiter.sv
// Strict-priority pick between the high and low queues, with a high-streak
// counter that forces one low grant after HI_BURST_MAX back-to-back highs.
module xmit_prio_arbiter
  import xmit_pkg::*;
#(
  parameter int HI_BURST_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        arb_en,
  input  logic        take,
  input  logic        hi_frame_valid,
  input  logic [23:0] hi_ctrl,
  input  logic        lo_frame_valid,
  input  logic [23:0] lo_ctrl,
  output logic        grant_hi,
  output logic        grant_lo,
  output logic [23:0] cand_ctrl
);

  localparam int STREAK_W = (HI_BURST_MAX < 1) ? 1 : $clog2(HI_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HI_BURST_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                starved;

  always_comb begin
    starved   = (HI_BURST_MAX != 0) && (streak_q == STREAK_MAX);
    grant_lo  = lo_frame_valid && (!hi_frame_valid || starved);
    grant_hi  = hi_frame_valid && !grant_lo;
    cand_ctrl = grant_lo ? lo_ctrl : hi_ctrl;

    streak_d = streak_q;
    if (arb_en) begin
      if (take && grant_hi) begin
        if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
      end else if (take && grant_lo) begin
        streak_d = '0;
      end else if (!hi_frame_valid) begin
        streak_d = '0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) streak_q <= '0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/xmit_frame_scheduler.sv
// Picks a frame from the high/low receive buffers, sequences its byte reads,
// starts the transmit engine or drains out-of-range frames, then holds an IFG.
module xmit_frame_scheduler
  import xmit_pkg::*;
#(
  parameter int MIN_LEN      = DEF_MIN_LEN,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int IFG_CYCLES   = 12,
  parameter int HI_BURST_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hi_frame_valid,
  input  logic [23:0] hi_ctrl,
  input  logic        lo_frame_valid,
  input  logic [23:0] lo_ctrl,
  input  logic        tx_ready,
  output logic        hi_ctrl_pop,
  output logic        lo_ctrl_pop,
  output logic        hi_data_rd,
  output logic        lo_data_rd,
  output logic        data_sel,
  output logic        tx_start,
  output logic [11:0] tx_len,
  output logic [11:0] tx_tag,
  output logic        discard_en,
  output logic        busy,
  output logic [15:0] hi_sent_cnt,
  output logic [15:0] lo_sent_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam int GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  state_e             state_q, state_d;
  logic [11:0]        byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               hi_ctrl_pop_q, hi_ctrl_pop_d, lo_ctrl_pop_q, lo_ctrl_pop_d;
  logic               hi_data_rd_q, hi_data_rd_d, lo_data_rd_q, lo_data_rd_d;
  logic               data_sel_q, data_sel_d, tx_start_q, tx_start_d;
  logic               discard_en_q, discard_en_d, busy_q, busy_d;
  logic [11:0]        tx_len_q, tx_len_d, tx_tag_q, tx_tag_d;
  logic [15:0]        hi_sent_cnt_q, hi_sent_cnt_d, lo_sent_cnt_q, lo_sent_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               arb_en, take, grant_hi, grant_lo, cand_good, rd_next;
  logic [23:0]        cand_ctrl;
  logic [11:0]        cand_len;

  xmit_prio_arbiter #(.HI_BURST_MAX(HI_BURST_MAX)) u_arb (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .arb_en         (arb_en),
    .take           (take),
    .hi_frame_valid (hi_frame_valid),
    .hi_ctrl        (hi_ctrl),
    .lo_frame_valid (lo_frame_valid),
    .lo_ctrl        (lo_ctrl),
    .grant_hi       (grant_hi),
    .grant_lo       (grant_lo),
    .cand_ctrl      (cand_ctrl)
  );

  // Bad frames are drained without waiting for the transmit engine.
  always_comb begin
    arb_en    = (state_q == ST_IDLE);
    cand_len  = ctrl_len(cand_ctrl);
    cand_good = (cand_len >= MIN_L) && (cand_len <= MAX_L);
    take      = arb_en && (grant_hi || grant_lo) && (tx_ready || !cand_good);
  end

  always_comb begin
    // NOTE: every _d starts from its hold value so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    hi_ctrl_pop_d = 1'b0;
    lo_ctrl_pop_d = 1'b0;
    tx_start_d    = 1'b0;
    discard_en_d  = 1'b0;
    rd_next       = 1'b0;
    data_sel_d    = data_sel_q;
    tx_len_d      = tx_len_q;
    tx_tag_d      = tx_tag_q;
    hi_sent_cnt_d = hi_sent_cnt_q;
    lo_sent_cnt_d = lo_sent_cnt_q;
    drop_cnt_d    = drop_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          data_sel_d    = grant_hi;
          hi_ctrl_pop_d = grant_hi;
          lo_ctrl_pop_d = grant_lo;
          byte_cnt_d    = cand_len;
          rd_next       = (cand_len != 12'd0);
          if (cand_good) begin
            state_d    = ST_XFER;
            tx_start_d = 1'b1;
            tx_len_d   = cand_len;
            tx_tag_d   = ctrl_tag(cand_ctrl);
            if (grant_hi) hi_sent_cnt_d = hi_sent_cnt_q + 16'd1;
            else          lo_sent_cnt_d = lo_sent_cnt_q + 16'd1;
          end else begin
            state_d      = ST_DRAIN;
            discard_en_d = 1'b1;
            drop_cnt_d   = drop_cnt_q + 16'd1;
          end
        end
      end
      // byte_cnt_q counts the read issued this cycle plus those still to come.
      ST_XFER, ST_DRAIN: begin
        if (byte_cnt_q > 12'd1) begin
          byte_cnt_d   = byte_cnt_q - 12'd1;
          rd_next      = 1'b1;
          discard_en_d = (state_q == ST_DRAIN);
        end else begin
          byte_cnt_d = '0;
          gap_cnt_d  = GAP_LOAD;
          state_d    = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    hi_data_rd_d = rd_next && data_sel_d;
    lo_data_rd_d = rd_next && !data_sel_d;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      hi_ctrl_pop_q <= 1'b0;
      lo_ctrl_pop_q <= 1'b0;
      hi_data_rd_q  <= 1'b0;
      lo_data_rd_q  <= 1'b0;
      data_sel_q    <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_len_q      <= '0;
      tx_tag_q      <= '0;
      discard_en_q  <= 1'b0;
      busy_q        <= 1'b0;
      hi_sent_cnt_q <= '0;
      lo_sent_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      hi_ctrl_pop_q <= hi_ctrl_pop_d;
      lo_ctrl_pop_q <= lo_ctrl_pop_d;
      hi_data_rd_q  <= hi_data_rd_d;
      lo_data_rd_q  <= lo_data_rd_d;
      data_sel_q    <= data_sel_d;
      tx_start_q    <= tx_start_d;
      tx_len_q      <= tx_len_d;
      tx_tag_q      <= tx_tag_d;
      discard_en_q  <= discard_en_d;
      busy_q        <= busy_d;
      hi_sent_cnt_q <= hi_sent_cnt_d;
      lo_sent_cnt_q <= lo_sent_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign hi_ctrl_pop = hi_ctrl_pop_q;
  assign lo_ctrl_pop = lo_ctrl_pop_q;
  assign hi_data_rd  = hi_data_rd_q;
  assign lo_data_rd  = lo_data_rd_q;
  assign data_sel    = data_sel_q;
  assign tx_start    = tx_start_q;
  assign tx_len      = tx_len_q;
  assign tx_tag      = tx_tag_q;
  assign discard_en  = discard_en_q;
  assign busy        = busy_q;
  assign hi_sent_cnt = hi_sent_cnt_q;
  assign lo_sent_cnt = lo_sent_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_xmit_frame_scheduler.sv
// Self-checking bench: directed scenarios plus random queue traffic, compared
// every cycle against a frame-level timing model of the scheduler.
module tb_xmit_frame_scheduler;

  localparam int IFG = 12;
  localparam int HB  = 4;

  logic        clk_sys, reset;
  logic        hi_frame_valid, lo_frame_valid, tx_ready;
  logic [23:0] hi_ctrl, lo_ctrl;
  logic        hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd;
  logic        data_sel, tx_start, discard_en, busy;
  logic [11:0] tx_len, tx_tag;
  logic [15:0] hi_sent_cnt, lo_sent_cnt, drop_cnt;

  xmit_frame_scheduler #(
    .MIN_LEN(64), .MAX_LEN(1518), .IFG_CYCLES(IFG), .HI_BURST_MAX(HB)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .hi_frame_valid (hi_frame_valid),
    .hi_ctrl        (hi_ctrl),
    .lo_frame_valid (lo_frame_valid),
    .lo_ctrl        (lo_ctrl),
    .tx_ready       (tx_ready),
    .hi_ctrl_pop    (hi_ctrl_pop),
    .lo_ctrl_pop    (lo_ctrl_pop),
    .hi_data_rd     (hi_data_rd),
    .lo_data_rd     (lo_data_rd),
    .data_sel       (data_sel),
    .tx_start       (tx_start),
    .tx_len         (tx_len),
    .tx_tag         (tx_tag),
    .discard_en     (discard_en),
    .busy           (busy),
    .hi_sent_cnt    (hi_sent_cnt),
    .lo_sent_cnt    (lo_sent_cnt),
    .drop_cnt       (drop_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream queues and frame-level reference model.
  logic [23:0] hq[$];
  logic [23:0] lq[$];
  int          e, next_arb, f_start, f_len, f_dur, streak;
  bit          f_hi, f_good;
  logic        m_sel;
  logic [11:0] m_len, m_tag;
  logic [15:0] m_hcnt, m_lcnt, m_dcnt;
  logic [79:0] exp_vec;

  // Observed activity, accumulated per scenario.
  int          o_hrd, o_lrd, o_disc, o_start, o_busy, o_pops;
  logic [15:0] o_order;

  function automatic logic [79:0] dut_vec();
    return {hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd, data_sel, tx_start,
            discard_en, busy, tx_len, tx_tag, hi_sent_cnt, lo_sent_cnt, drop_cnt};
  endfunction

  task automatic clear_stats();
    o_hrd = 0; o_lrd = 0; o_disc = 0; o_start = 0; o_busy = 0; o_pops = 0;
    o_order = '0;
  endtask

  task automatic model_reset();
    e = 0; next_arb = 0; f_start = -1000000; f_len = 0; f_dur = 0;
    f_hi = 1'b0; f_good = 1'b0; streak = 0;
    m_sel = 1'b0; m_len = '0; m_tag = '0; m_hcnt = '0; m_lcnt = '0; m_dcnt = '0;
    exp_vec = '0;
  endtask

  // Expected outputs after edge e, derived from the inputs being presented now.
  task automatic model_edge();
    bit          hv, lv, plo, phi, good, taken;
    logic [23:0] c;
    int          len, k;
    hv = hi_frame_valid;
    lv = lo_frame_valid;
    taken = 1'b0;
    if (e >= next_arb) begin
      plo = lv && (!hv || (HB != 0 && streak == HB));
      phi = hv && !plo;
      if (plo || phi) begin
        c    = phi ? hi_ctrl : lo_ctrl;
        len  = int'(c[23:12]);
        good = (len >= 64) && (len <= 1518);
        if (!good || tx_ready) begin
          taken    = 1'b1;
          f_start  = e;
          f_hi     = phi;
          f_good   = good;
          f_len    = len;
          f_dur    = (len == 0) ? 1 : len;
          next_arb = e + f_dur + IFG + 1;
          m_sel    = phi;
          if (good) begin
            m_len = c[23:12];
            m_tag = c[11:0];
            if (phi) m_hcnt++;
            else     m_lcnt++;
          end else begin
            m_dcnt++;
          end
          if (phi) begin
            if (streak < HB) streak++;
          end else begin
            streak = 0;
          end
        end
      end
      if (!taken && !hv) streak = 0;
    end
    k = e - f_start;
    exp_vec = {(k == 0) && f_hi, (k == 0) && !f_hi,
               (k >= 0) && (k < f_len) && f_hi, (k >= 0) && (k < f_len) && !f_hi,
               m_sel, (k == 0) && f_good,
               !f_good && (k >= 0) && (k < f_dur),
               (k >= 0) && (k < f_dur + IFG),
               m_len, m_tag, m_hcnt, m_lcnt, m_dcnt};
  endtask

  // One clock: retire popped heads, present inputs, predict, then compare.
  task automatic step(input bit rdy);
    if (exp_vec[79]) void'(hq.pop_front());
    if (exp_vec[78]) void'(lq.pop_front());
    hi_frame_valid = (hq.size() != 0);
    hi_ctrl        = (hq.size() != 0) ? hq[0] : 24'h0;
    lo_frame_valid = (lq.size() != 0);
    lo_ctrl        = (lq.size() != 0) ? lq[0] : 24'h0;
    tx_ready       = rdy;
    model_edge();
    e++;
    @(negedge clk_sys);
    check("cycle", dut_vec(), exp_vec);
    o_hrd   += int'(hi_data_rd);
    o_lrd   += int'(lo_data_rd);
    o_disc  += int'(discard_en);
    o_start += int'(tx_start);
    o_busy  += int'(busy);
    if (hi_ctrl_pop || lo_ctrl_pop) begin
      o_order = {o_order[14:0], hi_ctrl_pop};
      o_pops++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    reset = 1'b0;
    hi_frame_valid = 1'b0; lo_frame_valid = 1'b0; tx_ready = 1'b0;
    hi_ctrl = '0; lo_ctrl = '0;
    #1 check("reset", dut_vec(), 80'h0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b1;
    hq.delete();
    lq.delete();
    model_reset();
    clear_stats();
  endtask

  function automatic logic [23:0] rand_ctrl();
    int r, len;
    r = $urandom_range(0, 19);
    if (r == 0)      len = 0;
    else if (r == 1) len = $urandom_range(1, 63);
    else if (r == 2) len = $urandom_range(1519, 1560);
    else             len = $urandom_range(64, 128);
    return {12'(len), 12'($urandom_range(0, 4095))};
  endfunction

  initial begin
    int n;
    reset = 1'b0;
    hi_frame_valid = 1'b0; lo_frame_valid = 1'b0; tx_ready = 1'b0;
    hi_ctrl = '0; lo_ctrl = '0;
    model_reset();
    clear_stats();

    // Single minimum-length high frame.
    apply_reset();
    hq.push_back(24'h040040);
    repeat (90) step(1'b1);
    check("t1_pops",  80'(o_pops), 80'd1);
    check("t1_start", 80'(o_start), 80'd1);
    check("t1_len",   80'(tx_len), 80'd64);
    check("t1_tag",   80'(tx_tag), 80'h040);
    check("t1_rd",    80'(o_hrd), 80'd64);
    check("t1_busy",  80'(o_busy), 80'd76);
    check("t1_sent",  80'(hi_sent_cnt), 80'd1);

    // Runt frame is drained.
    apply_reset();
    hq.push_back(24'h020001);
    repeat (60) step(1'b1);
    check("runt_disc",  80'(o_disc), 80'd32);
    check("runt_rd",    80'(o_hrd), 80'd32);
    check("runt_start", 80'(o_start), 80'd0);
    check("runt_drop",  80'(drop_cnt), 80'd1);

    // Zero length and one-over-max, both discarded; drain ignores tx_ready.
    apply_reset();
    hq.push_back(24'h000005);
    hq.push_back(24'h5EF006);
    repeat (1580) step(1'b0);
    check("bad_drop", 80'(drop_cnt), 80'd2);
    check("bad_disc", 80'(o_disc), 80'd1520);
    check("bad_rd",   80'(o_hrd), 80'd1519);

    // Length boundaries 63 / 64 / 1518.
    apply_reset();
    hq.push_back(24'h03F00A);
    hq.push_back(24'h04000B);
    hq.push_back(24'h5EE00C);
    repeat (1720) step(1'b1);
    check("bnd_drop", 80'(drop_cnt), 80'd1);
    check("bnd_sent", 80'(hi_sent_cnt), 80'd2);
    check("bnd_len",  80'(tx_len), 80'd1518);
    check("bnd_tag",  80'(tx_tag), 80'h00C);

    // Good frame held off by tx_ready.
    apply_reset();
    hq.push_back(24'h050077);
    repeat (10) step(1'b0);
    check("rdy_nopop", 80'(o_pops), 80'd0);
    step(1'b1);
    check("rdy_pop",   80'(hi_ctrl_pop), 80'd1);
    check("rdy_start", 80'(tx_start), 80'd1);
    repeat (100) step(1'b1);
    check("rdy_sent",  80'(hi_sent_cnt), 80'd1);

    // Both queues saturated: starvation guard interleaves low.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      hq.push_back(24'h040100 + 24'(i));
      lq.push_back(24'h040200 + 24'(i));
    end
    n = 0;
    while (o_pops < 10 && n < 3000) begin
      step(1'b1);
      n++;
    end
    check("burst_pops",  80'(o_pops), 80'd10);
    check("burst_order", 80'(o_order[9:0]), 80'(10'b1111011110));
    check("burst_lo",    80'(lo_sent_cnt), 80'd2);
    check("burst_hi",    80'(hi_sent_cnt), 80'd8);

    // Asynchronous reset in the middle of a transfer.
    apply_reset();
    hq.push_back(24'h0400AA);
    n = 0;
    while (o_hrd < 30 && n < 100) begin
      step(1'b1);
      n++;
    end
    check("mid_bytes", 80'(o_hrd), 80'd30);
    #2 reset = 1'b0;
    #1 check("async_rst", dut_vec(), 80'h0);
    @(negedge clk_sys);
    reset = 1'b1;
    hq.delete();
    lq.delete();
    model_reset();
    clear_stats();
    repeat (5) step(1'b1);
    check("post_rst", {32'h0, busy, hi_sent_cnt, lo_sent_cnt, drop_cnt}, 80'h0);

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 24) == 0 && hq.size() < 4) hq.push_back(rand_ctrl());
      if ($urandom_range(0, 24) == 0 && lq.size() < 4) lq.push_back(rand_ctrl());
      step($urandom_range(0, 3) != 0);
    end
    check("rand_total", 80'(hi_sent_cnt + lo_sent_cnt + drop_cnt), 80'(m_hcnt + m_lcnt + m_dcnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
